// File: rtl/udp_tx_rr_arbiter.sv
// udp_tx_rr_arbiter: round-robin arbiter merging S_COUNT UDP header+payload requesters onto one stream.
// A granted frame owns the output from header capture until its tlast beat.
module udp_tx_rr_arbiter #(
  parameter int S_COUNT = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT-1:0]            s_udp_hdr_valid,
  output logic [S_COUNT-1:0]            s_udp_hdr_ready,
  input  logic [S_COUNT*6-1:0]          s_udp_ip_dscp,
  input  logic [S_COUNT*2-1:0]          s_udp_ip_ecn,
  input  logic [S_COUNT*8-1:0]          s_udp_ip_ttl,
  input  logic [S_COUNT*32-1:0]         s_udp_ip_source_ip,
  input  logic [S_COUNT*32-1:0]         s_udp_ip_dest_ip,
  input  logic [S_COUNT*16-1:0]         s_udp_source_port,
  input  logic [S_COUNT*16-1:0]         s_udp_dest_port,
  input  logic [S_COUNT*16-1:0]         s_udp_length,
  input  logic [S_COUNT*16-1:0]         s_udp_checksum,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_udp_payload_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_udp_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_udp_payload_axis_tvalid,
  output logic [S_COUNT-1:0]            s_udp_payload_axis_tready,
  input  logic [S_COUNT-1:0]            s_udp_payload_axis_tlast,
  input  logic [S_COUNT-1:0]            s_udp_payload_axis_tuser,
  output logic                          m_udp_hdr_valid,
  input  logic                          m_udp_hdr_ready,
  output logic [5:0]                    m_udp_ip_dscp,
  output logic [1:0]                    m_udp_ip_ecn,
  output logic [7:0]                    m_udp_ip_ttl,
  output logic [31:0]                   m_udp_ip_source_ip,
  output logic [31:0]                   m_udp_ip_dest_ip,
  output logic [15:0]                   m_udp_source_port,
  output logic [15:0]                   m_udp_dest_port,
  output logic [15:0]                   m_udp_length,
  output logic [15:0]                   m_udp_checksum,
  output logic [DATA_WIDTH-1:0]         m_udp_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_udp_payload_axis_tkeep,
  output logic                          m_udp_payload_axis_tvalid,
  input  logic                          m_udp_payload_axis_tready,
  output logic                          m_udp_payload_axis_tlast,
  output logic                          m_udp_payload_axis_tuser,
  output logic                          busy,
  output logic [$clog2(S_COUNT)-1:0]    grant_index
);
  localparam int IW = $clog2(S_COUNT);
  localparam int HW = 144;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, winner, idx;
  logic [IW:0] sum;
  logic [HW-1:0] hdr_q, hdr_d;
  logic [HW-1:0] hdr_in [S_COUNT];
  logic [DATA_WIDTH-1:0] tdata_in [S_COUNT];
  logic [KEEP_WIDTH-1:0] tkeep_in [S_COUNT];
  logic hdr_valid_q, hdr_valid_d, found, rst_q, arb_en, pay_en, beat_last;
  for (genvar j = 0; j < S_COUNT; j++) begin : g_port
    assign hdr_in[j] = {s_udp_ip_dscp[j*6+:6], s_udp_ip_ecn[j*2+:2], s_udp_ip_ttl[j*8+:8],
                        s_udp_ip_source_ip[j*32+:32], s_udp_ip_dest_ip[j*32+:32],
                        s_udp_source_port[j*16+:16], s_udp_dest_port[j*16+:16],
                        s_udp_length[j*16+:16], s_udp_checksum[j*16+:16]};
    assign tdata_in[j] = s_udp_payload_axis_tdata[j*DATA_WIDTH+:DATA_WIDTH];
    assign tkeep_in[j] = s_udp_payload_axis_tkeep[j*KEEP_WIDTH+:KEEP_WIDTH];
  end
  // Descending scan so the port closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    winner = rr_ptr_q;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = S_COUNT-1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
      sum = (sum >= (IW+1)'(S_COUNT)) ? sum - (IW+1)'(S_COUNT) : sum;
      idx = sum[IW-1:0];
      if (s_udp_hdr_valid[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  // Arbitration is held off for one cycle after reset so no handshake straddles it.
  assign arb_en = (state_q == IDLE) && !rst && !rst_q;
  assign pay_en = (state_q == PAYLOAD) && !rst;
  assign s_udp_hdr_ready = (arb_en && found) ? {{(S_COUNT-1){1'b0}}, 1'b1} << winner : '0;
  assign s_udp_payload_axis_tready = pay_en ? ({{(S_COUNT-1){1'b0}}, m_udp_payload_axis_tready} << grant_q) : '0;
  assign m_udp_payload_axis_tvalid = pay_en && s_udp_payload_axis_tvalid[grant_q];
  assign m_udp_payload_axis_tdata = tdata_in[grant_q];
  assign m_udp_payload_axis_tkeep = tkeep_in[grant_q];
  assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast[grant_q];
  assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser[grant_q];
  assign beat_last = m_udp_payload_axis_tvalid && m_udp_payload_axis_tready && m_udp_payload_axis_tlast;
  assign {m_udp_ip_dscp, m_udp_ip_ecn, m_udp_ip_ttl, m_udp_ip_source_ip, m_udp_ip_dest_ip,
          m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum} = hdr_q;
  assign m_udp_hdr_valid = hdr_valid_q;
  assign busy = state_q != IDLE;
  assign grant_index = grant_q;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    hdr_valid_d = hdr_valid_q;
    hdr_d = hdr_q;
    if (arb_en && found) begin
      state_d = HDR;
      grant_d = winner;
      hdr_valid_d = 1'b1;
      hdr_d = hdr_in[winner];
    end
    if (state_q == HDR && m_udp_hdr_ready) begin
      state_d = PAYLOAD;
      hdr_valid_d = 1'b0;
    end
    if (state_q == PAYLOAD && beat_last) begin
      state_d = IDLE;
      rr_ptr_d = (grant_q == IW'(S_COUNT-1)) ? '0 : grant_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      hdr_valid_q <= 1'b0;
      hdr_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_q <= hdr_d;
    end
  end
endmodule

// File: tb/tb_udp_tx_rr_arbiter.sv
// tb_udp_tx_rr_arbiter: directed scenarios for the round-robin UDP transmit arbiter.
module tb_udp_tx_rr_arbiter;
  localparam int S = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  logic clk = 0, rst = 1;
  logic [S-1:0] s_udp_hdr_valid = '0, s_udp_hdr_ready;
  logic [S*6-1:0] s_udp_ip_dscp = '0;
  logic [S*2-1:0] s_udp_ip_ecn = '0;
  logic [S*8-1:0] s_udp_ip_ttl = '0;
  logic [S*32-1:0] s_udp_ip_source_ip = '0, s_udp_ip_dest_ip = '0;
  logic [S*16-1:0] s_udp_source_port = '0, s_udp_dest_port = '0, s_udp_length = '0, s_udp_checksum = '0;
  logic [S*DW-1:0] s_tdata = '0;
  logic [S*KW-1:0] s_tkeep = '1;
  logic [S-1:0] s_tvalid = '0, s_tready, s_tlast = '0, s_tuser = '0;
  logic m_udp_hdr_valid, m_udp_hdr_ready = 1;
  logic [5:0] m_udp_ip_dscp;
  logic [1:0] m_udp_ip_ecn;
  logic [7:0] m_udp_ip_ttl;
  logic [31:0] m_udp_ip_source_ip, m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic m_tvalid, m_tready = 1, m_tlast, m_tuser, busy;
  logic [1:0] grant_index;
  int checks = 0, errors = 0;

  udp_tx_rr_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_udp_ip_dscp(s_udp_ip_dscp), .s_udp_ip_ecn(s_udp_ip_ecn), .s_udp_ip_ttl(s_udp_ip_ttl),
    .s_udp_ip_source_ip(s_udp_ip_source_ip), .s_udp_ip_dest_ip(s_udp_ip_dest_ip),
    .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
    .s_udp_length(s_udp_length), .s_udp_checksum(s_udp_checksum),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tkeep(s_tkeep),
    .s_udp_payload_axis_tvalid(s_tvalid), .s_udp_payload_axis_tready(s_tready),
    .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_udp_ip_dscp(m_udp_ip_dscp), .m_udp_ip_ecn(m_udp_ip_ecn), .m_udp_ip_ttl(m_udp_ip_ttl),
    .m_udp_ip_source_ip(m_udp_ip_source_ip), .m_udp_ip_dest_ip(m_udp_ip_dest_ip),
    .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
    .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
    .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
    .busy(busy), .grant_index(grant_index)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hdr(input int p, input logic [31:0] dip, input logic [15:0] len);
    s_udp_ip_dscp[p*6+:6] = 6'(p + 1);
    s_udp_ip_ecn[p*2+:2] = 2'(p);
    s_udp_ip_ttl[p*8+:8] = 8'(64 + p);
    s_udp_ip_source_ip[p*32+:32] = 32'h0A000000 + 32'(p);
    s_udp_ip_dest_ip[p*32+:32] = dip;
    s_udp_source_port[p*16+:16] = 16'(1000 + p);
    s_udp_dest_port[p*16+:16] = 16'(2000 + p);
    s_udp_length[p*16+:16] = len;
    s_udp_checksum[p*16+:16] = 16'hAB00 + 16'(p);
  endtask

  task automatic set_pay(input int p, input logic [63:0] d, input logic last, input logic user);
    s_tvalid[p] = 1'b1;
    s_tdata[p*DW+:DW] = d;
    s_tlast[p] = last;
    s_tuser[p] = user;
  endtask

  task automatic clr_pay(input int p);
    s_tvalid[p] = 1'b0;
    s_tlast[p] = 1'b0;
    s_tuser[p] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1;
    s_udp_hdr_valid = 4'b1111;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (m_udp_hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %0b exp 0", m_udp_hdr_valid); end
    checks++; if (grant_index !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d exp 0", grant_index); end
    checks++; if (m_udp_ip_dest_ip !== 32'h0) begin errors++; $display("FAIL reset_hdr_regs: got %h exp 0", m_udp_ip_dest_ip); end
    checks++; if (s_udp_hdr_ready !== 4'b0000) begin errors++; $display("FAIL reset_hdr_ready: got %b exp 0000", s_udp_hdr_ready); end
    checks++; if (s_tready !== 4'b0000 || m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_payload: tready %b tvalid %b exp 0000/0", s_tready, m_tvalid); end
    rst = 0;
    #1;
    checks++; if (s_udp_hdr_ready !== 4'b0000) begin errors++; $display("FAIL post_reset_ready: got %b exp 0000", s_udp_hdr_ready); end
    step();
    s_udp_hdr_valid = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy %0b exp 0", busy); end
  endtask

  task automatic test_single();
    set_hdr(2, 32'hC0A80105, 16'd16);
    s_udp_hdr_valid = 4'b0100;
    m_udp_hdr_ready = 1;
    #1;
    checks++; if (s_udp_hdr_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", s_udp_hdr_ready); end
    step();
    s_udp_hdr_valid = '0;
    checks++; if (m_udp_hdr_valid !== 1'b1 || grant_index !== 2'd2) begin errors++; $display("FAIL single_grant: valid %0b grant %0d exp 1/2", m_udp_hdr_valid, grant_index); end
    checks++; if (m_udp_ip_dest_ip !== 32'hC0A80105 || m_udp_length !== 16'd16) begin errors++; $display("FAIL single_fields: dip %h len %0d exp c0a80105/16", m_udp_ip_dest_ip, m_udp_length); end
    checks++; if (m_udp_source_port !== 16'd1002 || m_udp_ip_ttl !== 8'd66 || m_udp_checksum !== 16'hAB02 || m_udp_ip_dscp !== 6'd3) begin errors++; $display("FAIL single_fields2: sport %0d ttl %0d csum %h dscp %0d", m_udp_source_port, m_udp_ip_ttl, m_udp_checksum, m_udp_ip_dscp); end
    set_pay(2, 64'h1111_2222_3333_4444, 0, 0);
    step();
    checks++; if (m_udp_hdr_valid !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL single_beat1: hv %0b tv %0b data %h", m_udp_hdr_valid, m_tvalid, m_tdata); end
    checks++; if (s_tready !== 4'b0100) begin errors++; $display("FAIL single_tready: got %b exp 0100", s_tready); end
    step();
    set_pay(2, 64'h5555_6666_7777_8888, 1, 0);
    #1;
    checks++; if (m_tdata !== 64'h5555_6666_7777_8888 || m_tlast !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_beat2: data %h last %0b busy %0b", m_tdata, m_tlast, busy); end
    step();
    clr_pay(2);
    checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd3 || grant_index !== 2'd2) begin errors++; $display("FAIL single_end: busy %0b rr %0d grant %0d exp 0/3/2", busy, dut.rr_ptr_q, grant_index); end
  endtask

  task automatic test_round_robin();
    rst = 1;
    step();
    rst = 0;
    step();
    for (int p = 0; p < S; p++) set_hdr(p, 32'hC0A80100 + 32'(p), 16'(8 + p));
    s_udp_hdr_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      #1;
      checks++; if (s_udp_hdr_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_ready_%0d: got %b exp port %0d", k, s_udp_hdr_ready, e); end
      step();
      checks++; if (grant_index !== 2'(e) || m_udp_hdr_valid !== 1'b1 || m_udp_ip_dest_ip !== 32'hC0A80100 + 32'(e)) begin errors++; $display("FAIL rr_grant_%0d: grant %0d hv %0b dip %h exp %0d", k, grant_index, m_udp_hdr_valid, m_udp_ip_dest_ip, e); end
      step();
      set_pay(e, 64'(k), 1, 0);
      #1;
      checks++; if (m_tvalid !== 1'b1 || s_tready !== 4'(1 << e) || s_udp_hdr_ready !== 4'b0000) begin errors++; $display("FAIL rr_payload_%0d: tv %0b tready %b hready %b", k, m_tvalid, s_tready, s_udp_hdr_ready); end
      step();
      clr_pay(e);
    end
    s_udp_hdr_valid = '0;
  endtask

  task automatic test_hdr_stall();
    set_hdr(0, 32'hDEADBEEF, 16'd100);
    s_udp_hdr_valid = 4'b0001;
    m_udp_hdr_ready = 0;
    #1;
    checks++; if (s_udp_hdr_ready !== 4'b0001) begin errors++; $display("FAIL stall_wrap_ready: got %b exp 0001", s_udp_hdr_ready); end
    step();
    s_udp_hdr_valid = '0;
    set_hdr(0, 32'h0, 16'd0);
    set_pay(0, 64'hFEED, 1, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (m_udp_hdr_valid !== 1'b1 || m_udp_ip_dest_ip !== 32'hDEADBEEF || m_udp_length !== 16'd100) begin errors++; $display("FAIL stall_hdr_%0d: hv %0b dip %h len %0d", i, m_udp_hdr_valid, m_udp_ip_dest_ip, m_udp_length); end
      checks++; if (s_tready !== 4'b0000 || m_tvalid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_pay_%0d: tready %b tv %0b busy %0b", i, s_tready, m_tvalid, busy); end
      step();
    end
    m_udp_hdr_ready = 1;
    step();
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 64'hFEED || grant_index !== 2'd0) begin errors++; $display("FAIL stall_release: tv %0b data %h grant %0d", m_tvalid, m_tdata, grant_index); end
    step();
    clr_pay(0);
  endtask

  task automatic test_payload_stall();
    set_hdr(2, 32'h01020304, 16'd24);
    s_udp_hdr_valid = 4'b0100;
    step();
    s_udp_hdr_valid = '0;
    step();
    set_pay(2, 64'hA1, 0, 0);
    step();
    m_tready = 0;
    set_hdr(1, 32'h05060708, 16'd32);
    s_udp_hdr_valid = 4'b0010;
    set_pay(2, 64'hA2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_udp_hdr_ready !== 4'b0000 || s_tready !== 4'b0000 || m_tvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL pstall_%0d: hready %b tready %b tv %0b busy %0b", i, s_udp_hdr_ready, s_tready, m_tvalid, busy); end
      step();
    end
    m_tready = 1;
    #1;
    checks++; if (s_udp_hdr_ready !== 4'b0000 || s_tready !== 4'b0100) begin errors++; $display("FAIL pstall_last: hready %b tready %b exp 0000/0100", s_udp_hdr_ready, s_tready); end
    step();
    clr_pay(2);
    checks++; if (s_udp_hdr_ready !== 4'b0010 || busy !== 1'b0) begin errors++; $display("FAIL pstall_next: hready %b busy %0b exp 0010/0", s_udp_hdr_ready, busy); end
    s_udp_hdr_valid = '0;
    step();
    checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL pstall_withdraw: busy %0b rr %0d exp 0/3", busy, dut.rr_ptr_q); end
  endtask

  task automatic test_reset_mid_frame();
    set_hdr(3, 32'h0A0B0C0D, 16'd40);
    s_udp_hdr_valid = 4'b1000;
    step();
    s_udp_hdr_valid = '0;
    step();
    set_pay(3, 64'hB1, 0, 0);
    step();
    checks++; if (busy !== 1'b1 || grant_index !== 2'd3) begin errors++; $display("FAIL rmid_pre: busy %0b grant %0d exp 1/3", busy, grant_index); end
    rst = 1;
    #1;
    checks++; if (s_tready !== 4'b0000 || s_udp_hdr_ready !== 4'b0000) begin errors++; $display("FAIL rmid_during: tready %b hready %b exp 0", s_tready, s_udp_hdr_ready); end
    step();
    rst = 0;
    clr_pay(3);
    set_hdr(1, 32'h11111111, 16'd8);
    s_udp_hdr_valid = 4'b1010;
    #1;
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0 || grant_index !== 2'd0 || s_udp_hdr_ready !== 4'b0000) begin errors++; $display("FAIL rmid_after: busy %0b tv %0b grant %0d hready %b", busy, m_tvalid, grant_index, s_udp_hdr_ready); end
    step();
    checks++; if (busy !== 1'b0 || s_udp_hdr_ready !== 4'b0010) begin errors++; $display("FAIL rmid_search: busy %0b hready %b exp 0/0010", busy, s_udp_hdr_ready); end
    step();
    s_udp_hdr_valid = '0;
    checks++; if (grant_index !== 2'd1 || m_udp_ip_dest_ip !== 32'h11111111) begin errors++; $display("FAIL rmid_grant: grant %0d dip %h exp 1", grant_index, m_udp_ip_dest_ip); end
    step();
    set_pay(1, 64'hC1, 1, 0);
    step();
    clr_pay(1);
  endtask

  task automatic test_tuser();
    set_hdr(0, 32'h22222222, 16'd16);
    s_udp_hdr_valid = 4'b0001;
    step();
    s_udp_hdr_valid = '0;
    checks++; if (grant_index !== 2'd0) begin errors++; $display("FAIL tuser_grant: got %0d exp 0", grant_index); end
    step();
    set_pay(0, 64'hAAAA, 0, 1);
    #1;
    checks++; if (m_tuser !== 1'b1 || m_tlast !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 64'hAAAA) begin errors++; $display("FAIL tuser_fwd: user %0b last %0b tv %0b data %h", m_tuser, m_tlast, m_tvalid, m_tdata); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tuser_continue: busy %0b exp 1", busy); end
    set_pay(0, 64'hBBBB, 1, 0);
    #1;
    checks++; if (m_tuser !== 1'b0 || m_tlast !== 1'b1) begin errors++; $display("FAIL tuser_last: user %0b last %0b exp 0/1", m_tuser, m_tlast); end
    step();
    clr_pay(0);
    checks++; if (busy !== 1'b0 || dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL tuser_end: busy %0b rr %0d exp 0/1", busy, dut.rr_ptr_q); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hdr_stall();
    test_payload_stall();
    test_reset_mid_frame();
    test_tuser();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/udp_tx_rr_arbiter.md
UDP_TX_RR_ARBITER -- requirements
Module: udp_tx_rr_arbiter

Interface
REQ-001 Parameter S_COUNT, default 4, number of UDP transmit requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 64, payload tdata width.
REQ-003 Parameter KEEP_WIDTH, default DATA_WIDTH/8, payload tkeep width.
REQ-004 clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s_udp_hdr_valid / s_udp_hdr_ready  in / out  S_COUNT  per-requester header handshake.
REQ-007 s_udp_ip_dscp, s_udp_ip_ecn, s_udp_ip_ttl  in  S_COUNT*6, *2, *8  per-requester IP fields, packed with port 0 at LSBs.
REQ-008 s_udp_ip_source_ip, s_udp_ip_dest_ip  in  S_COUNT*32 each  per-requester addresses.
REQ-009 s_udp_source_port, s_udp_dest_port, s_udp_length, s_udp_checksum  in  S_COUNT*16 each  per-requester UDP fields.
REQ-010 s_udp_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  S_COUNT*DATA_WIDTH, S_COUNT*KEEP_WIDTH, S_COUNT x4  per-requester payload streams.
REQ-011 m_udp_hdr_valid out 1, m_udp_hdr_ready in 1, and m_udp_* header fields out (same widths as one requester)  shared header toward the UDP stack.
REQ-012 m_udp_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  DATA_WIDTH, KEEP_WIDTH, 1 x4  shared payload stream.
REQ-013 busy  out  1  high while state is not IDLE.
REQ-014 grant_index  out  $clog2(S_COUNT)  index of the current or most recent grantee.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, HDR, PAYLOAD.
REQ-016 IDLE: winner = first port with s_udp_hdr_valid set, searching from pointer rr_ptr upward with wrap modulo S_COUNT; s_udp_hdr_ready[winner] SHALL be 1 combinationally and all other ready bits 0.
REQ-017 IDLE with no hdr_valid: all s_udp_hdr_ready 0; state, rr_ptr and grant_index unchanged.
REQ-018 On the IDLE edge with a winner: header fields of the winner captured into output registers, grant_index <= winner, m_udp_hdr_valid <= 1, state -> HDR.
REQ-019 HDR: m_udp_hdr_valid held 1 and header registers stable until m_udp_hdr_ready=1; on that edge m_udp_hdr_valid <= 0, state -> PAYLOAD.
REQ-020 All s_udp_hdr_ready SHALL be 0 outside IDLE.
REQ-021 PAYLOAD: m_udp_payload_axis_* = slice grant_index of s_udp_payload_axis_*, combinationally; s_udp_payload_axis_tready[grant_index] = m_udp_payload_axis_tready; all other payload tready bits 0.
REQ-022 Outside PAYLOAD: m_udp_payload_axis_tvalid = 0 and all s payload tready = 0; no beats are transferred.
REQ-023 PAYLOAD exits only on a beat with tvalid & tready & tlast: state -> IDLE, rr_ptr <= (grant_index+1) mod S_COUNT.
REQ-024 tuser is passed through unmodified; a tuser=1 beat does not end the frame or alter arbitration.
REQ-025 Header-to-first-header latency: 1 cycle from a hdr_valid sampled in IDLE to m_udp_hdr_valid; minimum gap between frames is 1 IDLE cycle.
REQ-026 A requester deasserting hdr_valid before grant loses nothing; no fairness state is consumed.
REQ-027 Frames are never interleaved; a granted frame holds the output until its tlast beat, regardless of other requests or m tready stalls.

Reset
REQ-028 While rst=1 (sampled on clk): state IDLE, rr_ptr 0, grant_index 0, m_udp_hdr_valid 0, header registers 0, busy 0.
REQ-029 rst asserted mid-frame SHALL abort it on the next edge; the partial frame is not resumed and the first post-reset grant searches from port 0.
REQ-030 During and in the cycle after reset, no s_udp_hdr_ready or payload tready bit is asserted.

Verification
REQ-031 Single request: port 2 header (dest_ip C0A80105, length 16) + 2-beat payload, ready always 1 -> m_udp_hdr_valid one cycle later with identical fields, 2 beats out, grant_index 2, rr_ptr 3.
REQ-032 All four ports request continuously after reset -> grant order 0,1,2,3,0; no overlap between frames.
REQ-033 m_udp_hdr_ready held 0 for 5 cycles -> header fields and m_udp_hdr_valid stable, no payload tready asserted, busy 1.
REQ-034 Payload stall: m tready 0 for 3 cycles mid-frame while port 1 requests -> port 1 s_udp_hdr_ready stays 0 until the granted frame's tlast handshake.
REQ-035 rst pulsed during PAYLOAD of port 3 -> next cycle busy 0, m tvalid 0; with ports 1 and 3 requesting, port 1 granted first.
REQ-036 Beat with tuser=1, tlast=0 -> forwarded with tuser=1; frame continues to tlast.
